spi_byte_slave: RTL and testbench
=================================

Name: spi_byte_slave

Overview:
SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames) that runs entirely in the system clock domain. It oversamples SCK, SSEL and MOSI with synchronisers. It presents each received byte with a one-cycle strobe, and requests each byte to transmit through a level-style request. It sits between an external SPI master pin interface and on-chip command/data logic.

Parameters:
SYNC_STAGES, 3, synchroniser depth for sck/ssel/mosi (minimum 2; edge detect uses the last two stages)
WIDTH, 8, frame width in bits (bench uses 8)

Ports:
clk  in  1  system clock; must be at least 4x faster than sck
rst_n  in  1  synchronous active-low reset
sck  in  1  SPI clock from master, idle low
mosi  in  1  master-out serial data
miso  out  1  slave-out serial data, MSB first
ssel  in  1  slave select, active low
byteReceived  out  1  one-clk strobe: receivedData holds a new byte
receivedData  out  WIDTH  last complete received byte
dataNeeded  out  1  level request: dataToSend is sampled at the next load event
dataToSend  in  WIDTH  byte to shift out

Behaviour:
- Synchronisers: sck, ssel and mosi each pass through SYNC_STAGES flops on clk.
- sck_rise/sck_fall come from the last two sck stages; ssel_start is the high-to-low transition of the synced ssel; active = synced ssel low.
- Reset (rst_n=0 at posedge clk): bit_cnt=0, rx_shift=0, tx_shift=0, receivedData=0, byteReceived=0, dataNeeded=0, miso=0, load_pending=0. Synchroniser flops reset to idle values (sck=0, ssel=1, mosi=0).
- Receive, on each sck_rise while active: rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt++.
- On the rise that completes bit WIDTH-1: receivedData <= assembled byte, byteReceived=1 for exactly one clk (the following cycle), bit_cnt wraps to 0, load_pending=1.
- Transmit load events:
  - (a) ssel_start: tx_shift <= dataToSend, load_pending=0.
  - (b) first sck_fall while active with load_pending=1: tx_shift <= dataToSend, load_pending=0.
- Transmit shift: on any other sck_fall while active, tx_shift <= {tx_shift[WIDTH-2:0],0}.
- miso = tx_shift[WIDTH-1] while active; 0 while inactive. There is no tristate.
- Bit 0 of the first frame is therefore valid before the first sck rise. Later bits change only on sck falls, so they are stable across the master's sampling rise.
- dataNeeded = !active OR load_pending, registered. The requester must hold dataToSend valid while dataNeeded is high. The sampled value is whatever dataToSend is on the load cycle.
- ssel deasserted mid-frame: bit_cnt=0, load_pending=0, partial byte discarded, no byteReceived. Next ssel_start reloads tx.
- sck edges while inactive are ignored.
- ssel_start coincident with sck_fall: load (a) wins.
- Reset mid-frame: all state returns to reset values immediately. The frame is lost.
- Frames back-to-back without ssel toggling are supported indefinitely via load_pending.

Decomposition:
- Shared package: WIDTH default constant; SPI mode constant (mode 0) for documentation/asserts.
- One natural sub-module: spi_input_sync, the parameterised N-stage synchroniser with rise/fall detect, instantiated for sck and ssel (mosi uses the plain sync output).

Test Plan:
- Reset with rst_n=0 for 5 clks, ssel=1 -> miso=0, byteReceived=0, receivedData=0x00, dataNeeded=0 during reset, 1 after release (ssel high).
- ssel low, dataToSend=0xFF, 8 mode-0 bits of mosi=1 (10ns phases, clk 2ns) -> miso sampled after each sck rise reads 0xFF; one byteReceived pulse with receivedData=0xFF.
- Continue without raising ssel, change dataToSend to 0x00 before next sck fall, send mosi=0x00 -> miso reads 0x00, byteReceived pulse with receivedData=0x00.
- Send 0xA5 while dataToSend=0x3C -> receivedData=0xA5, miso stream 0,0,1,1,1,1,0,0.
- Raise ssel after 4 bits, lower again and send 0x81 -> no byteReceived for the partial frame; next frame gives receivedData=0x81 and a fresh dataToSend load.
- Assert rst_n=0 mid-frame after 3 bits, release, send 0x5A -> receivedData=0x5A (no bit misalignment).

Source files
------------

// File: rtl/spi_byte_slave_pkg.sv
// Shared constants for the SPI byte slave.
//   SPI_WIDTH       : default frame width in bits
//   SPI_SYNC_STAGES : default synchroniser depth for sck/ssel/mosi
//   SPI_MODE        : SPI mode implemented (CPOL=0, CPHA=0)
package spi_byte_slave_pkg;
  localparam int unsigned SPI_WIDTH       = 8;
  localparam int unsigned SPI_SYNC_STAGES = 3;
  localparam int unsigned SPI_MODE        = 0;
endpackage

// File: rtl/spi_input_sync.sv
// N-stage synchroniser with edge detection on the last two stages.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronised level (last stage)
//   rise, fall : one-clk strobes for a 0->1 / 1->0 transition of level
module spi_input_sync
  import spi_byte_slave_pkg::*;
#(
  parameter int unsigned STAGES    = SPI_SYNC_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync_q[0] is the newest sample, sync_q[STAGES-1] the oldest
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Edge is flagged one cycle before level itself changes
  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall  = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave (MSB first) running in the system clock domain.
//   clk, rst_n   : system clock (>= 4x sck), synchronous active-low reset
//   sck, mosi    : SPI clock / master data from the pins
//   ssel         : slave select, active low
//   miso         : slave data, MSB first, 0 while not selected
//   byteReceived : one-clk strobe, receivedData holds a new byte
//   receivedData : last complete received byte
//   dataNeeded   : dataToSend is sampled at the next load event
//   dataToSend   : byte to shift out
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES,
  parameter int unsigned WIDTH       = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic             ssel,
  output logic             byteReceived,
  output logic [WIDTH-1:0] receivedData,
  output logic             dataNeeded,
  input  logic [WIDTH-1:0] dataToSend
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic ssel_level, ssel_rise_unused, ssel_start;
  logic active, mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       received_data_q, received_data_d;
  logic                   byte_received_q, byte_received_d;
  logic                   data_needed_q, data_needed_d;
  logic                   miso_q, miso_d;
  logic                   load_pending_q, load_pending_d;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ssel),
    .level (ssel_level),
    .rise  (ssel_rise_unused),
    .fall  (ssel_start)
  );

  assign active = ~ssel_level;
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    received_data_d = received_data_q;
    byte_received_d = 1'b0;
    load_pending_d  = load_pending_q;

    // Receive side; deselect drops any partial byte
    if (!active) begin
      bit_cnt_d      = '0;
      load_pending_d = 1'b0;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d       = '0;
        received_data_d = {rx_shift_q[WIDTH-2:0], mosi_s};
        byte_received_d = 1'b1;
        load_pending_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // Transmit side; ssel_start occurs while still inactive, so it
    // takes priority over any coincident sck fall.
    if (ssel_start) begin
      tx_shift_d     = dataToSend;
      load_pending_d = 1'b0;
    end else if (active && sck_fall) begin
      if (load_pending_q) begin
        tx_shift_d     = dataToSend;
        load_pending_d = 1'b0;
      end else begin
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end
    end

    data_needed_d = ~active | load_pending_q;
    miso_d        = active ? tx_shift_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q     <= '0;
      bit_cnt_q       <= '0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      received_data_q <= '0;
      byte_received_q <= 1'b0;
      data_needed_q   <= 1'b0;
      miso_q          <= 1'b0;
      load_pending_q  <= 1'b0;
    end else begin
      mosi_sync_q     <= mosi_sync_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      received_data_q <= received_data_d;
      byte_received_q <= byte_received_d;
      data_needed_q   <= data_needed_d;
      miso_q          <= miso_d;
      load_pending_q  <= load_pending_d;
    end
  end

  assign miso         = miso_q;
  assign byteReceived = byte_received_q;
  assign receivedData = received_data_q;
  assign dataNeeded   = data_needed_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed self-checking bench for spi_byte_slave (mode 0, 8-bit frames).
module tb_spi_byte_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       ssel;
  logic       byteReceived;
  logic [7:0] receivedData;
  logic       dataNeeded;
  logic [7:0] dataToSend;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rx_count = 0;
  int unsigned hi_cycles = 0;
  logic [7:0]  last_rx = '0;
  logic        br_prev = 1'b0;
  logic [7:0]  miso_byte;

  spi_byte_slave #(.SYNC_STAGES(3), .WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso),
    .ssel         (ssel),
    .byteReceived (byteReceived),
    .receivedData (receivedData),
    .dataNeeded   (dataNeeded),
    .dataToSend   (dataToSend)
  );

  always #1 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (byteReceived && !br_prev) begin
      rx_count = rx_count + 1;
      last_rx  = receivedData;
    end
    if (byteReceived) hi_cycles = hi_cycles + 1;
    br_prev = byteReceived;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One mode-0 transfer of nbits, 10-unit phases. miso is captured just
  // before each rising sck edge. dataToSend is changed to next_tx after
  // the last rise so the following fall loads it.
  task automatic spi_xfer(input logic [7:0] mosi_byte, input int unsigned nbits,
                          input logic [7:0] next_tx, input bit chk,
                          output logic [7:0] rx_miso);
    logic [7:0] mb;
    rx_miso = '0;
    mb = mosi_byte;
    for (int unsigned k = 0; k < nbits; k++) begin
      mosi = mb[7-k];
      #10;
      rx_miso[7-k] = miso;
      sck = 1'b1;
      if (chk && k == 3) check_eq("dn_midframe", {31'b0, dataNeeded}, 32'd0);
      if (k == 7) dataToSend = next_tx;
      #10;
      if (chk && k == 7) check_eq("dn_frame_end", {31'b0, dataNeeded}, 32'd1);
      sck = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sck = 1'b0;
    mosi = 1'b0;
    ssel = 1'b1;
    dataToSend = 8'hFF;

    // Reset, deselected
    #10;
    check_eq("rst_miso", {31'b0, miso}, 32'd0);
    check_eq("rst_strobe", {31'b0, byteReceived}, 32'd0);
    check_eq("rst_rxdata", {24'b0, receivedData}, 32'h00);
    check_eq("rst_dn", {31'b0, dataNeeded}, 32'd0);
    rst_n = 1'b1;
    #6;
    check_eq("idle_dn", {31'b0, dataNeeded}, 32'd1);

    // sck activity while deselected must be ignored
    spi_xfer(8'hFF, 8, 8'hFF, 1'b0, miso_byte);
    #20;
    check_eq("inactive_count", rx_count, 32'd0);
    check_eq("inactive_miso", {31'b0, miso}, 32'd0);

    // Frame 1: all ones both ways
    ssel = 1'b0;
    #10;
    spi_xfer(8'hFF, 8, 8'h00, 1'b1, miso_byte);
    check_eq("f1_miso", {24'b0, miso_byte}, 32'hFF);
    check_eq("f1_count", rx_count, 32'd1);
    check_eq("f1_rx", {24'b0, last_rx}, 32'hFF);

    // Frame 2: back-to-back, all zeros
    spi_xfer(8'h00, 8, 8'h3C, 1'b1, miso_byte);
    check_eq("f2_miso", {24'b0, miso_byte}, 32'h00);
    check_eq("f2_count", rx_count, 32'd2);
    check_eq("f2_rx", {24'b0, last_rx}, 32'h00);

    // Frame 3: mixed pattern
    spi_xfer(8'hA5, 8, 8'h00, 1'b1, miso_byte);
    check_eq("f3_miso", {24'b0, miso_byte}, 32'h3C);
    check_eq("f3_count", rx_count, 32'd3);
    check_eq("f3_rx", {24'b0, last_rx}, 32'hA5);

    // Partial frame aborted by deselect
    spi_xfer(8'hF0, 4, 8'h00, 1'b0, miso_byte);
    ssel = 1'b1;
    #20;
    check_eq("abort_count", rx_count, 32'd3);
    check_eq("abort_dn", {31'b0, dataNeeded}, 32'd1);
    check_eq("abort_miso", {31'b0, miso}, 32'd0);
    dataToSend = 8'hC3;
    ssel = 1'b0;
    #10;
    spi_xfer(8'h81, 8, 8'h77, 1'b1, miso_byte);
    check_eq("f4_miso", {24'b0, miso_byte}, 32'hC3);
    check_eq("f4_count", rx_count, 32'd4);
    check_eq("f4_rx", {24'b0, last_rx}, 32'h81);

    // Reset in the middle of a frame
    spi_xfer(8'hFF, 3, 8'h00, 1'b0, miso_byte);
    rst_n = 1'b0;
    #4;
    check_eq("mid_rst_rxdata", {24'b0, receivedData}, 32'h00);
    check_eq("mid_rst_miso", {31'b0, miso}, 32'd0);
    check_eq("mid_rst_dn", {31'b0, dataNeeded}, 32'd0);
    dataToSend = 8'h96;
    #6;
    rst_n = 1'b1;
    #20;
    spi_xfer(8'h5A, 8, 8'h00, 1'b1, miso_byte);
    check_eq("f5_miso", {24'b0, miso_byte}, 32'h96);
    check_eq("f5_count", rx_count, 32'd5);
    check_eq("f5_rx", {24'b0, last_rx}, 32'h5A);

    ssel = 1'b1;
    #20;
    check_eq("strobe_width", hi_cycles, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
